// File: rtl/cva6_axi_txn_scheduler.sv
// Round-robin scheduler sharing one AXI AR/AW channel between cache requesters, with ID pool,
// per-ID owner tracking and an outstanding-write cap. Optional FENCE drain: CVA6_AXI_SCHED_DRAIN_EN.
module cva6_axi_txn_scheduler #(
  parameter int unsigned NR_REQ             = 3,
  parameter int unsigned ID_WIDTH           = 4,
  parameter int unsigned MAX_WR_OUTSTANDING = 7,
  localparam int unsigned OWN_W  = (NR_REQ > 1) ? $clog2(NR_REQ) : 1,
  localparam int unsigned WCNT_W = $clog2(MAX_WR_OUTSTANDING + 1),
  localparam int unsigned NR_ID  = 2 ** ID_WIDTH
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NR_REQ-1:0]   req_valid_i,
  input  logic [NR_REQ-1:0]   req_write_i,
  output logic [NR_REQ-1:0]   req_ready_o,
  output logic                axi_valid_o,
  input  logic                axi_ready_i,
  output logic [ID_WIDTH-1:0] axi_id_o,
  output logic                axi_write_o,
  output logic [OWN_W-1:0]    axi_owner_o,
  input  logic                rsp_valid_i,
  input  logic [ID_WIDTH-1:0] rsp_id_i,
  input  logic                rsp_last_i,
  output logic [OWN_W-1:0]    rsp_owner_o,
  output logic                rsp_spurious_o,
  output logic [ID_WIDTH:0]   outstanding_o,
`ifdef CVA6_AXI_SCHED_DRAIN_EN
  input  logic                drain_req_i,
  output logic                drain_done_o,
`endif
  output logic [WCNT_W-1:0]   wr_outstanding_o
);

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e                  state_q, state_d;
  logic [NR_ID-1:0]        busy_q, busy_d;
  logic [NR_ID-1:0]        wr_q, wr_d;
  logic [OWN_W-1:0]        owner_q [NR_ID];
  logic [OWN_W-1:0]        owner_d [NR_ID];
  logic [ID_WIDTH:0]       outstanding_q, outstanding_d;
  logic [WCNT_W-1:0]       wr_cnt_q, wr_cnt_d;
  logic [OWN_W-1:0]        rr_q, rr_d;
  logic [ID_WIDTH-1:0]     axi_id_q, axi_id_d;
  logic                    axi_write_q, axi_write_d;
  logic [OWN_W-1:0]        axi_owner_q, axi_owner_d;

  logic                    drain_block;
  logic                    can_grant;
  logic [NR_REQ-1:0]       eligible;
  logic                    grant;
  logic [OWN_W-1:0]        gnt_idx;
  logic                    gnt_write;
  logic [ID_WIDTH-1:0]     alloc_id;
  logic                    free_hit;
  logic                    wr_free;

`ifdef CVA6_AXI_SCHED_DRAIN_EN
  logic drain_done_q, drain_done_d;
  assign drain_block  = drain_req_i;
  assign drain_done_d = drain_req_i && (outstanding_q == '0) && (state_q == StIdle);
  assign drain_done_o = drain_done_q;
`else
  assign drain_block = 1'b0;
`endif

  // Allocation reads only the registered bitmap, so an ID freed this cycle is not reused yet.
  always_comb begin
    alloc_id = '0;
    for (int i = NR_ID - 1; i >= 0; i--) begin
      if (!busy_q[i]) alloc_id = ID_WIDTH'(i);
    end
  end

  assign can_grant = (state_q == StIdle) && !(&busy_q) && !drain_block;

  always_comb begin
    for (int i = 0; i < NR_REQ; i++) begin
      eligible[i] = can_grant && req_valid_i[i] &&
                    (!req_write_i[i] || (wr_cnt_q < WCNT_W'(MAX_WR_OUTSTANDING)));
    end
  end

  // Two passes give a rotating search: first from the RR pointer upward, then wrap to 0.
  always_comb begin
    grant   = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NR_REQ; i++) begin
      if (!grant && eligible[i] && (OWN_W'(i) >= rr_q)) begin
        grant   = 1'b1;
        gnt_idx = OWN_W'(i);
      end
    end
    for (int i = 0; i < NR_REQ; i++) begin
      if (!grant && eligible[i]) begin
        grant   = 1'b1;
        gnt_idx = OWN_W'(i);
      end
    end
    for (int i = 0; i < NR_REQ; i++) begin
      req_ready_o[i] = grant && (gnt_idx == OWN_W'(i));
    end
  end

  assign gnt_write = |(req_ready_o & req_write_i);
  assign free_hit  = rsp_valid_i && rsp_last_i && busy_q[rsp_id_i];
  assign wr_free   = free_hit && wr_q[rsp_id_i];

  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    wr_d          = wr_q;
    owner_d       = owner_q;
    outstanding_d = outstanding_q;
    wr_cnt_d      = wr_cnt_q;
    rr_d          = rr_q;
    axi_id_d      = axi_id_q;
    axi_write_d   = axi_write_q;
    axi_owner_d   = axi_owner_q;

    unique case (state_q)
      StIdle:  if (grant) state_d = StIssue;
      StIssue: if (axi_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (free_hit) busy_d[rsp_id_i] = 1'b0;
    if (grant) begin
      busy_d[alloc_id]  = 1'b1;
      wr_d[alloc_id]    = gnt_write;
      owner_d[alloc_id] = gnt_idx;
      axi_id_d          = alloc_id;
      axi_write_d       = gnt_write;
      axi_owner_d       = gnt_idx;
      rr_d              = (gnt_idx == OWN_W'(NR_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end

    unique case ({grant, free_hit})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase

    unique case ({grant && gnt_write, wr_free})
      2'b10:   wr_cnt_d = wr_cnt_q + 1'b1;
      2'b01:   wr_cnt_d = wr_cnt_q - 1'b1;
      default: wr_cnt_d = wr_cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      busy_q        <= '0;
      wr_q          <= '0;
      owner_q       <= '{default: '0};
      outstanding_q <= '0;
      wr_cnt_q      <= '0;
      rr_q          <= '0;
      axi_id_q      <= '0;
      axi_write_q   <= 1'b0;
      axi_owner_q   <= '0;
`ifdef CVA6_AXI_SCHED_DRAIN_EN
      drain_done_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      wr_q          <= wr_d;
      owner_q       <= owner_d;
      outstanding_q <= outstanding_d;
      wr_cnt_q      <= wr_cnt_d;
      rr_q          <= rr_d;
      axi_id_q      <= axi_id_d;
      axi_write_q   <= axi_write_d;
      axi_owner_q   <= axi_owner_d;
`ifdef CVA6_AXI_SCHED_DRAIN_EN
      drain_done_q  <= drain_done_d;
`endif
    end
  end

  assign axi_valid_o      = (state_q == StIssue);
  assign axi_id_o         = axi_id_q;
  assign axi_write_o      = axi_write_q;
  assign axi_owner_o      = axi_owner_q;
  assign outstanding_o    = outstanding_q;
  assign wr_outstanding_o = wr_cnt_q;
  assign rsp_spurious_o   = rsp_valid_i && !busy_q[rsp_id_i];
  assign rsp_owner_o      = busy_q[rsp_id_i] ? owner_q[rsp_id_i] : '0;

endmodule

// File: tb/tb_cva6_axi_txn_scheduler.sv
// Directed bench for cva6_axi_txn_scheduler (default build, drain feature off).
module tb_cva6_axi_txn_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req_valid, req_write, req_ready;
  logic       axi_valid, axi_ready, axi_write;
  logic [3:0] axi_id, rsp_id;
  logic [1:0] axi_owner, rsp_owner;
  logic       rsp_valid, rsp_last, rsp_spurious;
  logic [4:0] outstanding;
  logic [2:0] wr_outstanding;

  int n_checks = 0;
  int n_pass   = 0;

  cva6_axi_txn_scheduler dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_valid_i     (req_valid),
    .req_write_i     (req_write),
    .req_ready_o     (req_ready),
    .axi_valid_o     (axi_valid),
    .axi_ready_i     (axi_ready),
    .axi_id_o        (axi_id),
    .axi_write_o     (axi_write),
    .axi_owner_o     (axi_owner),
    .rsp_valid_i     (rsp_valid),
    .rsp_id_i        (rsp_id),
    .rsp_last_i      (rsp_last),
    .rsp_owner_o     (rsp_owner),
    .rsp_spurious_o  (rsp_spurious),
    .outstanding_o   (outstanding),
    .wr_outstanding_o(wr_outstanding)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_write = '0;
    axi_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_id    = '0;
    rsp_last  = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  int exp_own [4] = '{0, 1, 2, 0};

  initial begin
    // Reset values and a single read from requester 1
    do_reset();
    check("rst_valid", 32'(axi_valid), 0);
    check("rst_outst", 32'(outstanding), 0);
    check("rst_wrout", 32'(wr_outstanding), 0);
    check("rst_ready", 32'(req_ready), 0);
    req_valid = 3'b010;
    #1 check("rd1_grant", 32'(req_ready), 32'b010);
    step();
    req_valid = '0;
    check("rd1_valid", 32'(axi_valid), 1);
    check("rd1_id", 32'(axi_id), 0);
    check("rd1_owner", 32'(axi_owner), 1);
    check("rd1_write", 32'(axi_write), 0);
    check("rd1_outst", 32'(outstanding), 1);
    step();
    check("rd1_hold_valid", 32'(axi_valid), 1);
    check("rd1_hold_id", 32'(axi_id), 0);
    axi_ready = 1'b1;
    step();
    check("rd1_done", 32'(axi_valid), 0);

    // Round robin with all three requesters asking continuously
    do_reset();
    axi_ready = 1'b1;
    req_valid = 3'b111;
    for (int k = 0; k < 4; k++) begin
      #1 check($sformatf("rr_grant%0d", k), 32'(req_ready), 32'(1 << exp_own[k]));
      step();
      check($sformatf("rr_id%0d", k), 32'(axi_id), 32'(k));
      check($sformatf("rr_own%0d", k), 32'(axi_owner), 32'(exp_own[k]));
      check($sformatf("rr_nb2b%0d", k), 32'(req_ready), 0);
      if (k == 3) req_valid = '0;
      step();
    end
    check("rr_outst", 32'(outstanding), 4);

    // Write cap: requester 2 issues writes with no B responses
    do_reset();
    axi_ready = 1'b1;
    req_valid = 3'b100;
    req_write = 3'b100;
    for (int i = 0; i < 7; i++) begin
      #1 check($sformatf("wr_grant%0d", i), 32'(req_ready), 32'b100);
      step();
      check($sformatf("wr_id%0d", i), 32'(axi_id), 32'(i));
      check($sformatf("wr_isw%0d", i), 32'(axi_write), 1);
      step();
    end
    #1 check("wr_cap_stall", 32'(req_ready), 0);
    check("wr_cap_cnt", 32'(wr_outstanding), 7);
    step();
    step();
    check("wr_cap_stall2", 32'(req_ready), 0);
    rsp_valid = 1'b1;
    rsp_id    = 4'd3;
    rsp_last  = 1'b1;
    #1 check("wr_b_owner", 32'(rsp_owner), 2);
    check("wr_b_spur", 32'(rsp_spurious), 0);
    step();
    rsp_valid = 1'b0;
    #1 check("wr_8th_grant", 32'(req_ready), 32'b100);
    check("wr_cnt_after_b", 32'(wr_outstanding), 6);
    step();
    req_valid = '0;
    check("wr_8th_valid", 32'(axi_valid), 1);
    check("wr_8th_id", 32'(axi_id), 3);
    check("wr_8th_cnt", 32'(wr_outstanding), 7);
    step();

    // ID pool exhaustion with reads from requesters 1 and 2
    do_reset();
    axi_ready = 1'b1;
    req_valid = 3'b110;
    for (int i = 0; i < 16; i++) begin
      step();
      step();
    end
    check("full_outst", 32'(outstanding), 16);
    #1 check("full_stall", 32'(req_ready), 0);
    rsp_valid = 1'b1;
    rsp_id    = 4'd9;
    rsp_last  = 1'b0;
    #1 check("full_owner9", 32'(rsp_owner), 2);
    step();
    check("full_nonlast", 32'(outstanding), 16);
    check("full_nonlast_stall", 32'(req_ready), 0);
    rsp_last = 1'b1;
    step();
    rsp_valid = 1'b0;
    rsp_last  = 1'b0;
    #1 check("full_regrant", 32'(req_ready), 32'b010);
    step();
    req_valid = '0;
    check("full_reuse_id", 32'(axi_id), 9);
    check("full_reuse_own", 32'(axi_owner), 1);
    step();

    // Write grant and write completion in the same cycle at wr_cnt=5
    do_reset();
    axi_ready = 1'b1;
    req_valid = 3'b001;
    req_write = 3'b001;
    for (int i = 0; i < 5; i++) begin
      step();
      step();
    end
    check("sim_cnt_pre", 32'(wr_outstanding), 5);
    rsp_valid = 1'b1;
    rsp_id    = 4'd0;
    rsp_last  = 1'b1;
    #1 check("sim_grant", 32'(req_ready), 32'b001);
    step();
    rsp_valid = 1'b0;
    req_valid = '0;
    check("sim_wrcnt", 32'(wr_outstanding), 5);
    check("sim_outst", 32'(outstanding), 5);
    check("sim_newid", 32'(axi_id), 5);
    step();

    // Spurious response on a free ID
    rsp_valid = 1'b1;
    rsp_id    = 4'd12;
    rsp_last  = 1'b1;
    #1 check("spur_pulse", 32'(rsp_spurious), 1);
    check("spur_owner", 32'(rsp_owner), 0);
    step();
    rsp_valid = 1'b0;
    #1 check("spur_clear", 32'(rsp_spurious), 0);
    check("spur_outst", 32'(outstanding), 5);
    check("spur_wrcnt", 32'(wr_outstanding), 5);

    // Reset with transactions in flight
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_outst", 32'(outstanding), 0);
    check("midrst_wrcnt", 32'(wr_outstanding), 0);
    check("midrst_valid", 32'(axi_valid), 0);
    rsp_valid = 1'b1;
    rsp_id    = 4'd1;
    #1 check("midrst_freed", 32'(rsp_spurious), 1);
    rsp_valid = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
